mem_resp_stage: RTL and testbench
=================================

Name: mem_resp_stage

Overview:
- Parametrised successor to the single-outstanding memory stage of the 5-stage MIPS pipeline; sits between EX and WB.
- Tracks up to MAX_OUTST in-flight data-sram-like load requests and buffers in-order responses in a response FIFO, so data_ok may arrive before the owning load reaches MS or while WB stalls.
- Aligns/extends load data for DW=32 or DW=64.
- On a WB exception flush, counts and silently drops responses belonging to flushed loads.

Parameters:
- DW, 32, data/register width; legal values 32 or 64.
- MAX_OUTST, 2, maximum in-flight requests plus buffered responses; legal range 1..4.
- PASS_WD, 128, opaque sideband width (pc, dest, cp0 fields) passed EX->WB unchanged.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- es_to_ms_valid  in  1  EX holds a valid instruction for MS.
- ms_allowin  out  1  MS can accept from EX.
- es_req_fire  in  1  EX issued a data request this cycle (req && addr_ok).
- ms_req_allow  out  1  EX may issue a new data request.
- es_load  in  1  instruction has an issued load request awaiting data.
- es_op  in  3  load type: 0 full-width, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LW-sign (DW=64 only).
- es_addr_low  in  log2(DW/8)  byte address low bits.
- es_gr_we  in  1  register write enable.
- es_ex  in  1  exception already detected upstream.
- es_eret  in  1  ERET.
- es_alu_result  in  DW  non-load result.
- es_pass  in  PASS_WD  sideband.
- data_dataok  in  1  response valid.
- data_rdata  in  DW  response data.
- flush  in  1  WB exception/eret flush.
- ws_allowin  in  1  WB can accept.
- ms_to_ws_valid  out  1  MS output valid.
- ms_result  out  DW  final result.
- ms_rf_we  out  DW/8  byte write enables.
- ms_pass  out  PASS_WD  sideband.
- ms_ex  out  1  exception.
- ms_handle_ex  out  1  ms_valid && (ms_ex || eret).

Behaviour:
- Reset (async, resetn=0):
  - ms_valid=0, inflight=0, cancel=0, FIFO empty.
  - ms_allowin=1, ms_req_allow=1, ms_to_ws_valid=0, ms_handle_ex=0, ms_rf_we=0.
  - Input register contents don't-care. Reset mid-operation discards everything; memory is reset together.
- inflight_next = inflight + es_req_fire - data_dataok.
- Drop rule: a response is dropped iff cancel!=0 or flush. If cancel!=0, cancel decrements by 1 per data_dataok.
- accept = data_dataok && cancel==0 && !flush.
- Flush cycle:
  - ms_valid<=0, FIFO cleared, cancel<=inflight_next.
  - The data_dataok and es_req_fire of that cycle are both counted as flushed.
- Response routing (strict in-order):
  - Bypass: if the FIFO is empty and MS holds a waiting load, the accepted response is consumed directly.
  - Otherwise the accepted response is pushed to the FIFO (depth MAX_OUTST).
- MS holds a waiting load when ms_valid && load_r.
- ms_ready_go = !load_r || fifo_cnt!=0 || accept.
- Data source is the FIFO head if non-empty, else data_rdata.
- Pop FIFO on ms_to_ws_valid && ws_allowin && load_r && fifo_cnt!=0.
- If bypass fires but ws_allowin=0, the data is pushed instead, so the bypass path never needs to hold data.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Input register loads when es_to_ms_valid && ms_allowin. ms_valid follows es_to_ms_valid when ms_allowin, except on flush.
- ms_req_allow = (inflight + fifo_cnt) < MAX_OUTST && !flush. FIFO overflow is therefore impossible; overflow is an assertion.
- Alignment (d = source data, a = es_addr_low registered):
  - LB/LBU: byte a, sign/zero extend to DW.
  - LH/LHU: halfword a[msb:1].
  - Op 0: d unchanged.
  - Op 7: word a[2], sign extend.
  - LWL/LWR: DW=32 only. LWL: d<<(8*(3-a)), rf_we = 1000/1100/1110/1111 for a=0..3. LWR: d>>(8*a), rf_we = 1111/0111/0011/0001 for a=0..3.
  - Ops 5/6 at DW=64 are illegal; result is undefined.
- Non-LWL/LWR: rf_we = all ones if gr_we, else 0.
- ms_result = load_r ? aligned : alu_result.
- ms_ex = ms_valid && es_ex. ms_rf_we forced to 0 when ms_ex.
- Simultaneous data_dataok && es_req_fire: inflight unchanged.

Test Plan:
- DW=32, LB at a=2, response 0x80FF_1234 arriving 3 cycles after MS entry -> ms_result=0xFFFF_FFFF, rf_we=1111, ms_to_ws_valid asserted the cycle data_dataok=1.
- LWL a=1, rdata 0xAABB_CCDD -> ms_result=0xCCDD_0000, rf_we=1100. LWR a=1 -> ms_result=0x00AA_BBCC, rf_we=0111.
- MAX_OUTST=2, two back-to-back loads, both responses arrive while ws_allowin=0 -> fifo_cnt=2, ms_req_allow=0. Both retire in order with correct data once ws_allowin=1.
- Flush with inflight=2 and no data_dataok -> cancel=2. Next two responses are dropped. A third load's response 0x1 is delivered to WB.
- DW=64, op 7, a=4, rdata 0x8000_0000_0000_0000 -> ms_result=0xFFFF_FFFF_8000_0000.
- resetn low mid-stall with fifo_cnt=1 -> asynchronously ms_to_ws_valid=0, fifo_cnt=0, inflight=0, ms_req_allow=1.

Source files
------------

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MS stage with multiple outstanding loads, in-order response FIFO and flush drop counting
module mem_resp_stage #(
    parameter int DW        = 32,
    parameter int MAX_OUTST = 2,
    parameter int PASS_WD   = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  es_to_ms_valid,
    output logic                  ms_allowin,
    input  logic                  es_req_fire,
    output logic                  ms_req_allow,
    input  logic                  es_load,
    input  logic [2:0]            es_op,
    input  logic [$clog2(DW/8)-1:0] es_addr_low,
    input  logic                  es_gr_we,
    input  logic                  es_ex,
    input  logic                  es_eret,
    input  logic [DW-1:0]         es_alu_result,
    input  logic [PASS_WD-1:0]    es_pass,
    input  logic                  data_dataok,
    input  logic [DW-1:0]         data_rdata,
    input  logic                  flush,
    input  logic                  ws_allowin,
    output logic                  ms_to_ws_valid,
    output logic [DW-1:0]         ms_result,
    output logic [DW/8-1:0]       ms_rf_we,
    output logic [PASS_WD-1:0]    ms_pass,
    output logic                  ms_ex,
    output logic                  ms_handle_ex
);
    localparam int NB = DW / 8;
    localparam int AW = $clog2(NB);
    localparam int CW = 3;
    localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
    localparam logic [CW:0] MAXO = (CW + 1)'(MAX_OUTST);
    localparam logic [NB-1:0] ONES = '1;

    logic ms_valid, load_r, gr_we_r, ex_r, eret_r;
    logic [2:0] op_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] alu_r;
    logic [PASS_WD-1:0] pass_r;
    logic [CW-1:0] inflight, inflight_next, cancel, fifo_cnt;
    logic [PW-1:0] wp, rp;
    logic [DW-1:0] fifo [MAX_OUTST];
    logic fifo_ne, accept, waiting, bypass, push, pop, ms_ready_go;
    logic [DW-1:0] src, aligned;
    logic [7:0] a8, byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;
    logic is_lwl, is_lwr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(MAX_OUTST - 1) ? '0 : p + PW'(1);
    endfunction

    assign fifo_ne        = fifo_cnt != '0;
    assign accept         = data_dataok && cancel == '0 && !flush;
    assign waiting        = ms_valid && load_r;
    // a bypass only happens when WB takes the data in the same cycle, otherwise it is parked
    assign bypass         = accept && !fifo_ne && waiting && ws_allowin;
    assign push           = accept && !bypass;
    assign ms_ready_go    = !load_r || fifo_ne || accept;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign pop            = ms_to_ws_valid && ws_allowin && load_r && fifo_ne;
    assign inflight_next  = inflight + CW'(es_req_fire) - CW'(data_dataok);
    assign ms_req_allow   = ({1'b0, inflight} + {1'b0, fifo_cnt}) < MAXO && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            inflight <= '0;
            cancel   <= '0;
            fifo_cnt <= '0;
            wp       <= '0;
            rp       <= '0;
        end else begin
            inflight <= inflight_next;
            if (flush) begin
                ms_valid <= 1'b0;
                cancel   <= inflight_next;
                fifo_cnt <= '0;
                wp       <= '0;
                rp       <= '0;
            end else begin
                if (ms_allowin) ms_valid <= es_to_ms_valid;
                if (cancel != '0 && data_dataok) cancel <= cancel - CW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
                if (push) wp <= inc(wp);
                if (pop) rp <= inc(rp);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            load_r  <= es_load;
            op_r    <= es_op;
            addr_r  <= es_addr_low;
            gr_we_r <= es_gr_we;
            ex_r    <= es_ex;
            eret_r  <= es_eret;
            alu_r   <= es_alu_result;
            pass_r  <= es_pass;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wp] <= data_rdata;
    end

    assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && fifo_cnt == CW'(MAX_OUTST)));

    assign src = fifo_ne ? fifo[rp] : data_rdata;

    always_comb begin
        a8      = 8'(addr_r);
        byte_v  = 8'(src >> {a8, 3'b0});
        half_v  = 16'(src >> {a8[7:1], 4'b0});
        word_v  = 32'(src >> {a8[7:2], 5'b0});
        aligned = op_r == 3'd1 ? DW'($signed(byte_v)) :
                  op_r == 3'd2 ? DW'(byte_v) :
                  op_r == 3'd3 ? DW'($signed(half_v)) :
                  op_r == 3'd4 ? DW'(half_v) :
                  op_r == 3'd5 ? src << {8'(NB - 1) - a8, 3'b0} :
                  op_r == 3'd6 ? src >> {a8, 3'b0} :
                  op_r == 3'd7 ? DW'($signed(word_v)) : src;
    end

    assign is_lwl       = load_r && op_r == 3'd5;
    assign is_lwr       = load_r && op_r == 3'd6;
    assign ms_result    = load_r ? aligned : alu_r;
    assign ms_rf_we     = (!ms_valid || ex_r) ? '0 :
                          is_lwl ? ~(ONES >> (a8 + 8'd1)) :
                          is_lwr ? ONES >> a8 :
                          gr_we_r ? ONES : '0;
    assign ms_pass      = pass_r;
    assign ms_ex        = ms_valid && ex_r;
    assign ms_handle_ex = ms_valid && (ex_r || eret_r);
endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: directed stimulus with a response scoreboard for 32- and 64-bit instances
module tb_mem_resp_stage;
    typedef struct packed {
        logic [63:0]  res;
        logic [7:0]   we;
        logic         ex;
        logic [127:0] pass;
    } exp_t;

    logic clk = 1'b0, resetn;
    always #5 clk = ~clk;

    logic es_to_ms_valid, ms_allowin, es_req_fire, ms_req_allow, es_load, es_gr_we, es_ex, es_eret;
    logic [2:0] es_op;
    logic [1:0] es_addr_low;
    logic [31:0] es_alu_result, data_rdata, ms_result;
    logic [127:0] es_pass, ms_pass;
    logic data_dataok, flush, ws_allowin, ms_to_ws_valid, ms_ex, ms_handle_ex;
    logic [3:0] ms_rf_we;

    logic w_es_to_ms_valid, w_ms_allowin, w_es_req_fire, w_ms_req_allow, w_es_load;
    logic [2:0] w_es_op, w_es_addr_low;
    logic [63:0] w_data_rdata, w_ms_result;
    logic [127:0] w_ms_pass;
    logic w_data_dataok, w_ms_to_ws_valid, w_ms_ex, w_ms_handle_ex;
    logic [7:0] w_ms_rf_we;

    exp_t q32[$], q64[$];
    int checks = 0, errors = 0;

    mem_resp_stage #(.DW(32), .MAX_OUTST(2), .PASS_WD(128)) u32 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_req_fire(es_req_fire), .ms_req_allow(ms_req_allow), .es_load(es_load), .es_op(es_op),
        .es_addr_low(es_addr_low), .es_gr_we(es_gr_we), .es_ex(es_ex), .es_eret(es_eret),
        .es_alu_result(es_alu_result), .es_pass(es_pass), .data_dataok(data_dataok),
        .data_rdata(data_rdata), .flush(flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_result(ms_result), .ms_rf_we(ms_rf_we),
        .ms_pass(ms_pass), .ms_ex(ms_ex), .ms_handle_ex(ms_handle_ex));

    mem_resp_stage #(.DW(64), .MAX_OUTST(2), .PASS_WD(128)) u64 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(w_es_to_ms_valid), .ms_allowin(w_ms_allowin),
        .es_req_fire(w_es_req_fire), .ms_req_allow(w_ms_req_allow), .es_load(w_es_load),
        .es_op(w_es_op), .es_addr_low(w_es_addr_low), .es_gr_we(1'b1), .es_ex(1'b0),
        .es_eret(1'b0), .es_alu_result(64'h0), .es_pass(128'h64), .data_dataok(w_data_dataok),
        .data_rdata(w_data_rdata), .flush(1'b0), .ws_allowin(1'b1),
        .ms_to_ws_valid(w_ms_to_ws_valid), .ms_result(w_ms_result), .ms_rf_we(w_ms_rf_we),
        .ms_pass(w_ms_pass), .ms_ex(w_ms_ex), .ms_handle_ex(w_ms_handle_ex));

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (q32.size() == 0) chk("m32_unexpected", {96'h0, ms_result}, 128'h0 - 1);
            else begin
                e = q32.pop_front();
                chk("m32_result", {96'h0, ms_result}, {64'h0, e.res});
                chk("m32_rf_we", {124'h0, ms_rf_we}, {120'h0, e.we});
                chk("m32_ex", {127'h0, ms_ex}, {127'h0, e.ex});
                chk("m32_pass", ms_pass, e.pass);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (resetn && w_ms_to_ws_valid) begin
            if (q64.size() == 0) chk("m64_unexpected", {64'h0, w_ms_result}, 128'h0 - 1);
            else begin
                e = q64.pop_front();
                chk("m64_result", {64'h0, w_ms_result}, {64'h0, e.res});
                chk("m64_rf_we", {120'h0, w_ms_rf_we}, {120'h0, e.we});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load32(input logic [2:0] op, input logic [1:0] a, input logic [127:0] pass,
                          input logic [31:0] res, input logic [3:0] we, input bit expect_it);
        es_to_ms_valid = 1'b1;
        es_req_fire    = 1'b1;
        es_load        = 1'b1;
        es_op          = op;
        es_addr_low    = a;
        es_gr_we       = 1'b1;
        es_ex          = 1'b0;
        es_pass        = pass;
        #1;
        chk("issue_allow", {126'h0, ms_allowin, ms_req_allow}, 128'h3);
        if (expect_it) q32.push_back('{res: {32'h0, res}, we: {4'h0, we}, ex: 1'b0, pass: pass});
        tick();
        es_to_ms_valid = 1'b0;
        es_req_fire    = 1'b0;
    endtask

    task automatic ld64(input logic [2:0] op, input logic [2:0] a, input logic [63:0] rdata,
                        input logic [63:0] res);
        w_es_to_ms_valid = 1'b1;
        w_es_req_fire    = 1'b1;
        w_es_load        = 1'b1;
        w_es_op          = op;
        w_es_addr_low    = a;
        q64.push_back('{res: res, we: 8'hFF, ex: 1'b0, pass: 128'h64});
        tick();
        w_es_to_ms_valid = 1'b0;
        w_es_req_fire    = 1'b0;
        w_data_dataok    = 1'b1;
        w_data_rdata     = rdata;
        tick();
        w_data_dataok    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; flush = 1'b0;
        es_to_ms_valid = 1'b0; es_req_fire = 1'b0; es_load = 1'b0; es_op = 3'd0; es_addr_low = 2'd0;
        es_gr_we = 1'b0; es_ex = 1'b0; es_eret = 1'b0; es_alu_result = '0; es_pass = '0;
        data_dataok = 1'b0; data_rdata = '0;
        w_es_to_ms_valid = 1'b0; w_es_req_fire = 1'b0; w_es_load = 1'b0; w_es_op = 3'd0;
        w_es_addr_low = 3'd0; w_data_dataok = 1'b0; w_data_rdata = '0;
        #3;
        chk("rst_allowin", {127'h0, ms_allowin}, 128'h1);
        chk("rst_req_allow", {127'h0, ms_req_allow}, 128'h1);
        chk("rst_valid", {127'h0, ms_to_ws_valid}, 128'h0);
        chk("rst_handle_ex", {127'h0, ms_handle_ex}, 128'h0);
        chk("rst_rf_we", {124'h0, ms_rf_we}, 128'h0);
        chk("rst64_valid", {127'h0, w_ms_to_ws_valid}, 128'h0);
        #9 resetn = 1'b1;
        tick();

        // LB a=2, response three cycles after MS entry
        load32(3'd1, 2'd2, 128'hA1, 32'hFFFF_FFFF, 4'hF, 1'b1);
        chk("lb_wait", {127'h0, ms_to_ws_valid}, 128'h0);
        tick();
        tick();
        data_dataok = 1'b1; data_rdata = 32'h80FF_1234;
        #1 chk("lb_valid_on_dataok", {127'h0, ms_to_ws_valid}, 128'h1);
        tick();
        data_dataok = 1'b0;

        load32(3'd5, 2'd1, 128'hA2, 32'hCCDD_0000, 4'b1100, 1'b1);
        data_dataok = 1'b1; data_rdata = 32'hAABB_CCDD;
        tick();
        data_dataok = 1'b0;
        load32(3'd6, 2'd1, 128'hA3, 32'h00AA_BBCC, 4'b0111, 1'b1);
        data_dataok = 1'b1; data_rdata = 32'hAABB_CCDD;
        tick();
        data_dataok = 1'b0;
        load32(3'd4, 2'd2, 128'hA4, 32'h0000_80FF, 4'hF, 1'b1);
        data_dataok = 1'b1; data_rdata = 32'h80FF_1234;
        tick();
        data_dataok = 1'b0;

        // non-load results, one carrying an exception
        es_to_ms_valid = 1'b1; es_load = 1'b0; es_gr_we = 1'b0; es_alu_result = 32'h1234_5678;
        es_pass = 128'hB1;
        q32.push_back('{res: 64'h1234_5678, we: 8'h0, ex: 1'b0, pass: 128'hB1});
        tick();
        es_gr_we = 1'b1; es_ex = 1'b1; es_alu_result = 32'hCAFE; es_pass = 128'hB2;
        q32.push_back('{res: 64'hCAFE, we: 8'h0, ex: 1'b1, pass: 128'hB2});
        tick();
        es_to_ms_valid = 1'b0; es_ex = 1'b0;
        #1 chk("handle_ex", {127'h0, ms_handle_ex}, 128'h1);
        tick();

        // two responses parked in the FIFO while WB stalls
        ws_allowin = 1'b0;
        load32(3'd0, 2'd0, 128'hC1, 32'h1111_1111, 4'hF, 1'b1);
        es_req_fire = 1'b1;
        tick();
        es_req_fire = 1'b0;
        data_dataok = 1'b1; data_rdata = 32'h1111_1111;
        tick();
        data_rdata = 32'h2222_2222;
        tick();
        data_dataok = 1'b0;
        #1;
        chk("full_req_allow", {127'h0, ms_req_allow}, 128'h0);
        chk("full_fifo_cnt", {125'h0, u32.fifo_cnt}, 128'h2);
        chk("full_allowin", {127'h0, ms_allowin}, 128'h0);
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1; es_load = 1'b1; es_op = 3'd0; es_pass = 128'hC2;
        q32.push_back('{res: 64'h2222_2222, we: 8'hF, ex: 1'b0, pass: 128'hC2});
        #1 chk("drain_allowin", {127'h0, ms_allowin}, 128'h1);
        tick();
        es_to_ms_valid = 1'b0;
        tick();

        // flush with two requests in flight
        load32(3'd0, 2'd0, 128'hD1, 32'h0, 4'h0, 1'b0);
        es_req_fire = 1'b1;
        tick();
        es_req_fire = 1'b0;
        flush = 1'b1;
        #1 chk("flush_req_allow", {127'h0, ms_req_allow}, 128'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_cancel", {125'h0, u32.cancel}, 128'h2);
        chk("flush_valid", {127'h0, ms_to_ws_valid}, 128'h0);
        data_dataok = 1'b1; data_rdata = 32'hDEAD;
        tick();
        data_rdata = 32'hBEEF;
        load32(3'd0, 2'd0, 128'hD3, 32'h0000_0001, 4'hF, 1'b1);
        data_rdata = 32'h1;
        #1 chk("after_flush_valid", {127'h0, ms_to_ws_valid}, 128'h1);
        tick();
        data_dataok = 1'b0;
        tick();

        // 64-bit alignment
        ld64(3'd7, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        ld64(3'd1, 3'd7, 64'h8500_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF85);
        ld64(3'd4, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
        ld64(3'd0, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // asynchronous reset in the middle of a WB stall
        ws_allowin = 1'b0;
        load32(3'd0, 2'd0, 128'hE1, 32'h0, 4'h0, 1'b0);
        data_dataok = 1'b1; data_rdata = 32'h5555;
        tick();
        data_dataok = 1'b0;
        #1 chk("pre_rst_fifo_cnt", {125'h0, u32.fifo_cnt}, 128'h1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", {127'h0, ms_to_ws_valid}, 128'h0);
        chk("arst_fifo_cnt", {125'h0, u32.fifo_cnt}, 128'h0);
        chk("arst_inflight", {125'h0, u32.inflight}, 128'h0);
        chk("arst_req_allow", {127'h0, ms_req_allow}, 128'h1);
        tick();
        resetn = 1'b1; ws_allowin = 1'b1;
        tick();
        tick();
        chk("q32_drained", 128'(q32.size()), 128'h0);
        chk("q64_drained", 128'(q64.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
